// File: rtl/adc_spi_reader_if.sv
// SPI pins of the gap-voltage ADC, plus the sample bus that feeds the
// permit/filter stage.
//
// Sample bus handshake: adc_valid is a one-cycle pulse per completed frame
// and has no ready. The consumer must take adc/adc_err in that cycle.
// Between pulses, adc and adc_err hold their last values.
interface adc_spi_reader_if #(
    parameter int ADC_WIDTH = 10
);
    logic                 spi_cs_n;
    logic                 spi_sclk;
    logic                 spi_miso;
    logic [ADC_WIDTH-1:0] adc;
    logic                 adc_err;
    logic                 adc_valid;

    modport master (
        output spi_cs_n,
        output spi_sclk,
        input  spi_miso,
        output adc,
        output adc_err,
        output adc_valid
    );

    modport slave (
        input  spi_cs_n,
        input  spi_sclk,
        output spi_miso,
        input  adc,
        input  adc_err,
        input  adc_valid
    );
endinterface

// File: rtl/adc_spi_reader.sv
// SPI master for the gap-voltage ADC. A free-running period timer starts
// each conversion. The block shifts in LEAD+DATA+TRAIL bits MSB first,
// checks that the framing bits are zero, and pulses adc_valid once per frame.
module adc_spi_reader #(
    parameter int ADC_WIDTH     = 10,
    parameter int LEAD_BITS     = 4,
    parameter int TRAIL_BITS    = 2,
    parameter int SCLK_HALF     = 4,
    parameter int SAMPLE_PERIOD = 10944
) (
    input  logic                    clk,
    input  logic                    aclr_n,
    input  logic                    sclr,
    input  logic                    enable,
    adc_spi_reader_if.master        bus,
    output logic                    overrun,
    output logic [2:0]              state_dbg
);
    localparam int FRAME = LEAD_BITS + ADC_WIDTH + TRAIL_BITS;
    localparam int PH_W  = $clog2(SCLK_HALF);
    localparam int BIT_W = $clog2(FRAME);
    localparam int TMR_W = $clog2(SAMPLE_PERIOD);

    // Ones over the data field. Every other frame bit must be zero.
    localparam logic [FRAME-1:0] DATA_MASK =
        FRAME'(((64'd1 << ADC_WIDTH) - 64'd1) << TRAIL_BITS);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [PH_W-1:0]    ph;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME-1:0]   shreg;
    logic               ovr_frame;
    logic               miso_s1;
    logic               miso_s2;
    logic [TMR_W-1:0]   tmr;
    logic               tick;

    assign state_dbg = state;

    // Two-flop synchroniser: miso is launched from the ADC's own timing.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= bus.spi_miso;
            miso_s2 <= miso_s1;
        end
    end

    // Sample-rate timer. It runs regardless of enable and ticks on each wrap.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            tmr  <= '0;
            tick <= 1'b0;
        end else if (sclr) begin
            tmr  <= '0;
            tick <= 1'b0;
        end else begin
            tmr  <= (tmr == TMR_LAST) ? '0 : tmr + TMR_W'(1);
            tick <= (tmr == TMR_LAST);
        end
    end

    // Frame sequencer. All SPI pins and the sample bus are registered here.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state         <= S_IDLE;
            ph            <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            ovr_frame     <= 1'b0;
            overrun       <= 1'b0;
            bus.spi_cs_n  <= 1'b1;
            bus.spi_sclk  <= 1'b1;
            bus.adc       <= '0;
            bus.adc_err   <= 1'b0;
            bus.adc_valid <= 1'b0;
        end else if (sclr) begin
            state         <= S_IDLE;
            ph            <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            ovr_frame     <= 1'b0;
            overrun       <= 1'b0;
            bus.spi_cs_n  <= 1'b1;
            bus.spi_sclk  <= 1'b1;
            bus.adc       <= '0;
            bus.adc_err   <= 1'b0;
            bus.adc_valid <= 1'b0;
        end else begin
            // A tick during a frame is dropped. It still taints that frame.
            if (tick && state != S_IDLE) begin
                overrun   <= 1'b1;
                ovr_frame <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (tick && enable) begin
                        state        <= S_SETUP;
                        ph           <= '0;
                        ovr_frame    <= 1'b0;
                        bus.spi_cs_n <= 1'b0;
                        bus.spi_sclk <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (ph != PH_LAST) begin
                        ph <= ph + PH_W'(1);
                    end else begin
                        state        <= S_SHIFT;
                        ph           <= '0;
                        bit_cnt      <= '0;
                        bus.spi_sclk <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (ph != PH_LAST) begin
                        ph <= ph + PH_W'(1);
                    end else begin
                        ph <= '0;
                        if (!bus.spi_sclk) begin
                            bus.spi_sclk <= 1'b1;
                        end else begin
                            // The last cycle of the high half is well clear
                            // of the ADC's falling-edge update.
                            shreg <= {shreg[FRAME-2:0], miso_s2};
                            if (bit_cnt == BIT_LAST) begin
                                state        <= S_HOLD;
                                bus.spi_cs_n <= 1'b1;
                            end else begin
                                bit_cnt      <= bit_cnt + BIT_W'(1);
                                bus.spi_sclk <= 1'b0;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (ph != PH_LAST) begin
                        ph <= ph + PH_W'(1);
                    end else begin
                        state         <= S_DONE;
                        ph            <= '0;
                        bus.adc       <= ADC_WIDTH'(shreg >> TRAIL_BITS);
                        bus.adc_err   <= (|(shreg & ~DATA_MASK)) | ovr_frame | tick;
                        bus.adc_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    bus.adc_valid <= 1'b0;
                end
                default: begin
                    state         <= S_IDLE;
                    bus.spi_cs_n  <= 1'b1;
                    bus.spi_sclk  <= 1'b1;
                    bus.adc_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader. dut_a runs at a sane sample period. dut_b's
// period is shorter than a frame, so every frame it produces is overrun.
module tb_adc_spi_reader;
    localparam int W     = 10;
    localparam int H     = 2;
    localparam int PA    = 200;
    localparam int PB    = 60;
    localparam int FBITS = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       aclr_n_a, sclr_a, en_a, ovr_a;
    logic       aclr_n_b, sclr_b, en_b, ovr_b;
    logic [2:0] st_a, st_b;

    adc_spi_reader_if #(.ADC_WIDTH(W)) bus_a ();
    adc_spi_reader_if #(.ADC_WIDTH(W)) bus_b ();

    adc_spi_reader #(.ADC_WIDTH(W), .SCLK_HALF(H), .SAMPLE_PERIOD(PA)) dut_a (
        .clk(clk), .aclr_n(aclr_n_a), .sclr(sclr_a), .enable(en_a),
        .bus(bus_a.master), .overrun(ovr_a), .state_dbg(st_a));

    adc_spi_reader #(.ADC_WIDTH(W), .SCLK_HALF(H), .SAMPLE_PERIOD(PB)) dut_b (
        .clk(clk), .aclr_n(aclr_n_b), .sclr(sclr_b), .enable(en_b),
        .bus(bus_b.master), .overrun(ovr_b), .state_dbg(st_b));

    // ---------------- reference model ----------------
    // Expected {err, data} for one 16-bit frame word.
    function automatic logic [W:0] ref_model(input logic [15:0] word, input bit overrun_seen);
        int lead, data, trail;
        lead  = int'(word) / 4096;
        data  = (int'(word) / 4) % 1024;
        trail = int'(word) % 4;
        return {(lead != 0) || (trail != 0) || overrun_seen, W'(data)};
    endfunction

    // ---------------- ADC models ----------------
    logic [15:0] word_a, word_b, sh_a, sh_b;
    int          idx_a, idx_b;
    logic [W:0]  exp_q[$];

    // ADC a: latch the word when cs falls, present the next bit on each sclk fall.
    always @(negedge bus_a.spi_cs_n or negedge bus_a.spi_sclk) begin
        if (bus_a.spi_sclk) begin
            sh_a  = word_a;
            idx_a = 0;
            exp_q.push_back(ref_model(word_a, 1'b0));
        end else if (!bus_a.spi_cs_n && idx_a < FBITS) begin
            bus_a.spi_miso <= sh_a[15-idx_a];
            idx_a++;
        end
    end

    // ADC b: same serial behaviour, fixed word.
    always @(negedge bus_b.spi_cs_n or negedge bus_b.spi_sclk) begin
        if (bus_b.spi_sclk) begin
            sh_b  = word_b;
            idx_b = 0;
        end else if (!bus_b.spi_cs_n && idx_b < FBITS) begin
            bus_b.spi_miso <= sh_b[15-idx_b];
            idx_b++;
        end
    end

    // ---------------- pin monitors ----------------
    int   low_cnt_a = 0, rises_a = 0, falls_a = 0, valids_a = 0, last_fall_a = 0;
    int   falls_b = 0, last_fall_b = 0;
    logic pcs_a = 1'b1, psclk_a = 1'b1, pcs_b = 1'b1;

    // Frame geometry seen on the pins: cs-low length, sclk rises, frame starts.
    always @(negedge clk) begin
        if (pcs_a && !bus_a.spi_cs_n) begin
            low_cnt_a   = 1;
            rises_a     = 0;
            falls_a++;
            last_fall_a = cyc;
        end else if (!bus_a.spi_cs_n) begin
            low_cnt_a++;
        end
        if (!psclk_a && bus_a.spi_sclk && !bus_a.spi_cs_n) rises_a++;
        if (bus_a.adc_valid) valids_a++;
        if (pcs_b && !bus_b.spi_cs_n) begin
            falls_b++;
            last_fall_b = cyc;
        end
        pcs_a   = bus_a.spi_cs_n;
        psclk_a = bus_a.spi_sclk;
        pcs_b   = bus_b.spi_cs_n;
    end

    // ---------------- scoreboard helpers ----------------
    int checks = 0;
    int errors = 0;
    int prev_fall_a = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fall_a(input int budget, output bit ok);
        int f0;
        f0 = falls_a;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (falls_a != f0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (bus_a.adc_valid) begin ok = 1'b1; break; end
        end
    endtask

    // One complete frame on dut_a, checked against the timing rules and the queue.
    task automatic frame_a(input string tag, input bit have_fall, input bit chk_gap);
        bit         ok;
        int         f;
        logic [W:0] e;
        if (!have_fall) begin
            wait_fall_a(2 * PA, ok);
            check({tag, "_cs_fall"}, 32'(ok), 1);
        end
        f = last_fall_a;
        if (chk_gap) check({tag, "_gap"}, 32'(f - prev_fall_a), PA);
        prev_fall_a = f;
        wait_valid_a(200, ok);
        check({tag, "_valid_seen"}, 32'(ok), 1);
        check({tag, "_latency"}, 32'(cyc - f), (2 + 2 * FBITS) * H);
        check({tag, "_cs_low"}, 32'(low_cnt_a), (1 + 2 * FBITS) * H);
        check({tag, "_sclk_rises"}, 32'(rises_a), FBITS);
        check({tag, "_sb_depth"}, 32'(exp_q.size()), 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_adc"}, 32'(bus_a.adc), 32'(e[W-1:0]));
        check({tag, "_err"}, 32'(bus_a.adc_err), 32'(e[W]));
        @(negedge clk); #1;
        check({tag, "_pulse"}, 32'(bus_a.adc_valid), 0);
    endtask

    function automatic logic [15:0] rand_word();
        logic [3:0] lead;
        logic [1:0] trail;
        logic [9:0] data;
        lead  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        trail = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        data  = 10'($urandom_range(0, 1023));
        return {lead, data, trail};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog no_finish observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit         ok;
        int         r, f0, v0, f1;
        logic [W:0] eb;

        aclr_n_a = 1'b0; sclr_a = 1'b0; en_a = 1'b1;
        aclr_n_b = 1'b0; sclr_b = 1'b0; en_b = 1'b1;
        bus_a.spi_miso = 1'b0;
        bus_b.spi_miso = 1'b0;
        word_a = 16'h0B34;
        word_b = {4'd0, 10'($urandom_range(1, 1023)), 2'd0};

        #12;
        check("rst_cs_n", 32'(bus_a.spi_cs_n), 1);
        check("rst_sclk", 32'(bus_a.spi_sclk), 1);
        check("rst_adc", 32'(bus_a.adc), 0);
        check("rst_err", 32'(bus_a.adc_err), 0);
        check("rst_valid", 32'(bus_a.adc_valid), 0);
        check("rst_overrun", 32'(ovr_a), 0);
        check("rst_b_overrun", 32'(ovr_b), 0);

        @(negedge clk);
        aclr_n_a = 1'b1;
        aclr_n_b = 1'b1;
        r = cyc;

        // First frame: timer wraps after SAMPLE_PERIOD cycles, cs falls one later.
        wait_fall_a(2 * PA, ok);
        check("first_cs_fall", 32'(ok), 1);
        check("first_tick_delay", 32'(last_fall_a - r), PA + 1);
        frame_a("basic", 1'b1, 1'b0);
        check("basic_adc_const", 32'(bus_a.adc), 32'h2CD);
        check("basic_err_const", 32'(bus_a.adc_err), 0);

        word_a = {4'b0100, 10'h3FF, 2'b00};
        frame_a("lead_bad", 1'b0, 1'b1);
        check("lead_bad_err_const", 32'(bus_a.adc_err), 1);

        word_a = 16'h0000;
        frame_a("zero", 1'b0, 1'b1);
        check("zero_adc_const", 32'(bus_a.adc), 0);

        for (int i = 0; i < 6; i++) begin
            word_a = rand_word();
            frame_a($sformatf("rand%0d", i), 1'b0, 1'b1);
        end

        // enable low for three periods: no frames at all.
        en_a = 1'b0;
        f0 = falls_a;
        v0 = valids_a;
        repeat (3 * PA) @(negedge clk);
        #1;
        check("disabled_cs_falls", 32'(falls_a - f0), 0);
        check("disabled_valids", 32'(valids_a - v0), 0);
        en_a = 1'b1;
        word_a = {4'd0, 10'h155, 2'd0};
        frame_a("resume", 1'b0, 1'b0);
        word_a = rand_word();
        frame_a("resume2", 1'b0, 1'b1);

        // sclr while bit 8 is on the wire aborts the frame.
        word_a = {4'd0, 10'h0F0, 2'd0};
        wait_fall_a(2 * PA, ok);
        check("sclr_cs_fall", 32'(ok), 1);
        for (int i = 0; i < 100; i++) begin
            if (rises_a >= 9) break;
            @(negedge clk); #1;
        end
        check("sclr_reached_bit8", 32'(rises_a), 9);
        sclr_a = 1'b1;
        @(negedge clk); #1;
        check("sclr_cs_n", 32'(bus_a.spi_cs_n), 1);
        check("sclr_sclk", 32'(bus_a.spi_sclk), 1);
        check("sclr_adc", 32'(bus_a.adc), 0);
        check("sclr_valid", 32'(bus_a.adc_valid), 0);
        sclr_a = 1'b0;
        r = cyc;
        exp_q.delete();
        v0 = valids_a;
        word_a = {4'd0, 10'h2AA, 2'd0};
        wait_fall_a(2 * PA, ok);
        check("sclr_restart_fall", 32'(ok), 1);
        check("sclr_no_valid", 32'(valids_a - v0), 0);
        check("sclr_restart_gap", 32'(last_fall_a - r), PA + 1);
        frame_a("after_sclr", 1'b1, 1'b0);

        // Asynchronous reset between clock edges, mid-frame.
        word_a = rand_word();
        wait_fall_a(2 * PA, ok);
        check("aclr_cs_fall", 32'(ok), 1);
        repeat (20) @(negedge clk);
        #2 aclr_n_a = 1'b0;
        #1;
        check("aclr_cs_n", 32'(bus_a.spi_cs_n), 1);
        check("aclr_sclk", 32'(bus_a.spi_sclk), 1);
        check("aclr_adc", 32'(bus_a.adc), 0);
        check("aclr_err", 32'(bus_a.adc_err), 0);
        check("aclr_valid", 32'(bus_a.adc_valid), 0);
        exp_q.delete();
        @(negedge clk);
        aclr_n_a = 1'b1;
        r = cyc;
        word_a = rand_word();
        wait_fall_a(2 * PA, ok);
        check("aclr_restart_fall", 32'(ok), 1);
        check("aclr_restart_gap", 32'(last_fall_a - r), PA + 1);
        frame_a("after_aclr", 1'b1, 1'b0);

        // dut_b: the frame outlasts the period, so every other tick is dropped.
        check("b_overrun_sticky", 32'(ovr_b), 1);
        ok = 1'b0;
        for (int i = 0; i < 4 * PB; i++) begin
            @(negedge clk); #1;
            if (bus_b.adc_valid) begin ok = 1'b1; break; end
        end
        eb = ref_model(word_b, 1'b1);
        check("b_valid_seen", 32'(ok), 1);
        check("b_adc", 32'(bus_b.adc), 32'(eb[W-1:0]));
        check("b_err", 32'(bus_b.adc_err), 32'(eb[W]));
        f0 = falls_b;
        for (int i = 0; i < 4 * PB; i++) begin
            @(negedge clk); #1;
            if (falls_b != f0) break;
        end
        f1 = last_fall_b;
        f0 = falls_b;
        for (int i = 0; i < 4 * PB; i++) begin
            @(negedge clk); #1;
            if (falls_b != f0) break;
        end
        check("b_frame_spacing", 32'(last_fall_b - f1), 2 * PB);
        sclr_b = 1'b1;
        @(negedge clk); #1;
        check("b_sclr_overrun", 32'(ovr_b), 0);
        check("b_sclr_cs_n", 32'(bus_b.spi_cs_n), 1);
        sclr_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
